// File: rtl/qbert_pkg.sv
// Shared jump codes, controller state type and cube indexing for the Q*bert jump controller.
package qbert_pkg;

  localparam logic [2:0] JUMP_NONE = 3'b000;
  localparam logic [2:0] JUMP_DR   = 3'b001;
  localparam logic [2:0] JUMP_DL   = 3'b010;
  localparam logic [2:0] JUMP_UR   = 3'b011;
  localparam logic [2:0] JUMP_UL   = 3'b100;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_MOVE  = 3'd3,
    ST_LAND  = 3'd4,
    ST_OVER  = 3'd5
  } ctrl_state_t;

  // Cubes are numbered row by row from the apex: row r starts at r(r+1)/2.
  function automatic int cube_index(input int row, input int col);
    return (row * (row + 1)) / 2 + col;
  endfunction

endpackage

// File: rtl/qbert_cube_index.sv
// Combinational jump target lookup: from cube (row,col) and a jump code, gives the
// one-hot target cube, its row/col, and whether the jump falls off the pyramid.
module qbert_cube_index
  import qbert_pkg::*;
#(
  parameter int N_ROWS = 7,
  parameter int N_cube = 28,
  parameter int RW     = 4
) (
  input  logic [RW-1:0]     row,
  input  logic [RW-1:0]     col,
  input  logic [2:0]        code,
  output logic [N_cube-1:0] target,
  output logic              bad,
  output logic [RW-1:0]     tgt_row,
  output logic [RW-1:0]     tgt_col
);

  always_comb begin
    tgt_row = row;
    tgt_col = col;
    bad     = 1'b0;
    case (code)
      JUMP_DR: begin
        bad     = (row == RW'(N_ROWS - 1));
        tgt_row = row + 1'b1;
        tgt_col = col + 1'b1;
      end
      JUMP_DL: begin
        bad     = (row == RW'(N_ROWS - 1));
        tgt_row = row + 1'b1;
      end
      // Going up keeps the column, so the rightmost cube of a row has no up-right neighbour.
      JUMP_UR: begin
        bad     = (row == '0) || (col == row);
        tgt_row = row - 1'b1;
      end
      JUMP_UL: begin
        bad     = (row == '0) || (col == '0);
        tgt_row = row - 1'b1;
        tgt_col = col - 1'b1;
      end
      default: ;
    endcase

    target = '0;
    if (code != JUMP_NONE && !bad)
      target = N_cube'(1) << cube_index(int'(tgt_row), int'(tgt_col));
  end

endmodule

// File: rtl/qbert_jump_ctrl.sv
// Q*bert jump controller: turns button edges into jump requests, tracks position and lives.
// Optional visited-cube tracking is enabled by defining QBERT_CUBE_VISIT_EN.
module qbert_jump_ctrl
  import qbert_pkg::*;
#(
  parameter int N_ROWS      = 7,
  parameter int N_cube      = 28,
  parameter int LIVES       = 3,
  parameter int ACK_TIMEOUT = 262144
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              btn_dr,
  input  logic              btn_dl,
  input  logic              btn_ur,
  input  logic              btn_ul,
  input  logic              e_start,
  input  logic              done_move,
  output logic              e_start_qb,
  output logic [2:0]        e_jump_qb,
  output logic [N_cube-1:0] e_next_qb,
  output logic [N_cube-1:0] position_qb,
  output logic              e_bad_jump,
  output logic [1:0]        lives,
  output logic              game_over,
  output logic              busy,
  output logic              ack_timeout,
  output logic [N_cube-1:0] visited_mask,
  output logic              all_visited
);

  localparam int RW = $clog2(N_ROWS) + 1;
  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(ACK_TIMEOUT - 1);

  ctrl_state_t       state_reg;
  logic              e_start_qb_reg;
  logic [2:0]        jump_reg;
  logic [N_cube-1:0] next_reg;
  logic              bad_reg;
  logic [N_cube-1:0] pos_reg;
  logic [RW-1:0]     row_reg, col_reg;
  logic [RW-1:0]     pend_row_reg, pend_col_reg;
  logic [1:0]        lives_reg;
  logic              over_reg;
  logic [TW-1:0]     cnt_reg;
  logic [3:0]        btn_prev_reg;

  logic [3:0]        btn_now;
  logic [3:0]        rise;
  logic [2:0]        sel_code;
  logic [N_cube-1:0] tgt_onehot;
  logic              tgt_bad;
  logic [RW-1:0]     tgt_row, tgt_col;

  assign btn_now = {btn_dr, btn_dl, btn_ur, btn_ul};
  assign rise    = btn_now & ~btn_prev_reg;

  always_comb begin
    sel_code = JUMP_NONE;
    if (rise[3])      sel_code = JUMP_DR;
    else if (rise[2]) sel_code = JUMP_DL;
    else if (rise[1]) sel_code = JUMP_UR;
    else if (rise[0]) sel_code = JUMP_UL;
  end

  qbert_cube_index #(
    .N_ROWS (N_ROWS),
    .N_cube (N_cube),
    .RW     (RW)
  ) u_cube_index (
    .row     (row_reg),
    .col     (col_reg),
    .code    (sel_code),
    .target  (tgt_onehot),
    .bad     (tgt_bad),
    .tgt_row (tgt_row),
    .tgt_col (tgt_col)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= ST_INIT;
      e_start_qb_reg <= 1'b0;
      jump_reg       <= JUMP_NONE;
      next_reg       <= '0;
      bad_reg        <= 1'b0;
      pos_reg        <= N_cube'(1);
      row_reg        <= '0;
      col_reg        <= '0;
      pend_row_reg   <= '0;
      pend_col_reg   <= '0;
      lives_reg      <= 2'(LIVES);
      over_reg       <= 1'b0;
      cnt_reg        <= '0;
      btn_prev_reg   <= '0;
    end else begin
      // Edge history always follows the buttons, so edges seen outside IDLE are lost.
      btn_prev_reg   <= btn_now;
      e_start_qb_reg <= 1'b0;
      case (state_reg)
        ST_INIT: begin
          pos_reg        <= N_cube'(1);
          row_reg        <= '0;
          col_reg        <= '0;
          e_start_qb_reg <= 1'b1;
          state_reg      <= ST_IDLE;
        end
        ST_IDLE: begin
          if (e_start) begin
            lives_reg <= 2'(LIVES);
            over_reg  <= 1'b0;
            state_reg <= ST_INIT;
          end else if (sel_code != JUMP_NONE) begin
            jump_reg     <= sel_code;
            next_reg     <= tgt_onehot;
            bad_reg      <= tgt_bad;
            pend_row_reg <= tgt_row;
            pend_col_reg <= tgt_col;
            cnt_reg      <= '0;
            state_reg    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (!done_move) begin
            state_reg <= ST_MOVE;
          end else if (cnt_reg == TO_LAST) begin
            jump_reg  <= JUMP_NONE;
            next_reg  <= '0;
            bad_reg   <= 1'b0;
            state_reg <= ST_IDLE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ST_MOVE: begin
          if (done_move) state_reg <= ST_LAND;
        end
        ST_LAND: begin
          jump_reg <= JUMP_NONE;
          next_reg <= '0;
          bad_reg  <= 1'b0;
          if (!bad_reg) begin
            pos_reg   <= next_reg;
            row_reg   <= pend_row_reg;
            col_reg   <= pend_col_reg;
            state_reg <= ST_IDLE;
          end else if (lives_reg == 2'd1) begin
            lives_reg <= 2'd0;
            over_reg  <= 1'b1;
            state_reg <= ST_OVER;
          end else begin
            lives_reg      <= lives_reg - 2'd1;
            pos_reg        <= N_cube'(1);
            row_reg        <= '0;
            col_reg        <= '0;
            e_start_qb_reg <= 1'b1;
            state_reg      <= ST_IDLE;
          end
        end
        ST_OVER: begin
          if (e_start) begin
            lives_reg <= 2'(LIVES);
            over_reg  <= 1'b0;
            state_reg <= ST_INIT;
          end
        end
        default: state_reg <= ST_INIT;
      endcase
    end
  end

  assign e_start_qb  = e_start_qb_reg;
  assign e_jump_qb   = jump_reg;
  assign e_next_qb   = next_reg;
  assign e_bad_jump  = bad_reg;
  assign position_qb = pos_reg;
  assign lives       = lives_reg;
  assign game_over   = over_reg;
  assign busy        = (state_reg == ST_ISSUE) || (state_reg == ST_MOVE) || (state_reg == ST_LAND);
  // Fires during the last ISSUE cycle the layer is allowed to acknowledge in.
  assign ack_timeout = (state_reg == ST_ISSUE) && done_move && (cnt_reg == TO_LAST);

`ifdef QBERT_CUBE_VISIT_EN
  logic [N_cube-1:0] visited_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      visited_reg <= N_cube'(1);
    else if (state_reg == ST_INIT)
      visited_reg <= N_cube'(1);
    else if (state_reg == ST_LAND && !bad_reg)
      visited_reg <= visited_reg | next_reg;
  end

  assign visited_mask = visited_reg;
  assign all_visited  = &visited_reg;
`else
  assign visited_mask = '0;
  assign all_visited  = 1'b0;
`endif

endmodule

// File: doc/qbert_jump_ctrl.md
QBERT_JUMP_CTRL -- requirements
Module: qbert_jump_ctrl

Interface
REQ-001 Parameter N_ROWS, default 7, number of pyramid rows.
REQ-002 Parameter N_cube, default 28, cube count; SHALL equal N_ROWS*(N_ROWS+1)/2.
REQ-003 Parameter LIVES, default 3, lives per game (1..3).
REQ-004 Parameter ACK_TIMEOUT, default 262144, cycles allowed for done_move to fall after a jump is issued.
REQ-005 Ports (name, direction, width, meaning):
- clk, in, 1: single clock.
- reset, in, 1: asynchronous, active-low reset.
- btn_dr / btn_dl / btn_ur / btn_ul, in, 1 each: direction buttons, synchronous to clk, level.
- e_start, in, 1: new-game request.
- done_move, in, 1: qbert_layer idle/landed flag.
- e_start_qb, out, 1: place Q*bert on the top cube.
- e_jump_qb, out, 3: jump code (001 DR, 010 DL, 011 UR, 100 UL, 000 none).
- e_next_qb, out, N_cube: one-hot target cube, or 0 if the jump is bad.
- position_qb, out, N_cube: one-hot current cube.
- e_bad_jump, out, 1: the issued jump leaves the pyramid.
- lives, out, 2: remaining lives.
- game_over, out, 1: no lives remain.
- busy, out, 1: a jump is in flight.
- ack_timeout, out, 1: one-cycle error pulse.
- visited_mask, out, N_cube; all_visited, out, 1: see REQ-020.

Function
REQ-006 Cube (r,c) SHALL have 0<=c<=r<N_ROWS and index r(r+1)/2+c; one-hot bit = index.
REQ-007 Targets SHALL be: DR (r+1,c+1), DL (r+1,c), UR (r-1,c), UL (r-1,c-1). A jump is bad if the target row is <0 or >=N_ROWS, or c<0, or c>row.
REQ-008 FSM states SHALL be INIT, IDLE, ISSUE, MOVE, LAND, OVER.
REQ-009 INIT: assert e_start_qb for exactly one cycle, then go to IDLE.
REQ-010 IDLE: on a rising edge of any button (one-register edge detect), in the same cycle, register e_jump_qb, e_next_qb and e_bad_jump, then go to ISSUE. Simultaneous edges SHALL use priority DR>DL>UR>UL.
REQ-011 ISSUE: hold all jump outputs stable.
- done_move==0: go to MOVE.
- Timeout counter reaches ACK_TIMEOUT-1: pulse ack_timeout, clear e_jump_qb, e_next_qb and e_bad_jump, leave position unchanged, go to IDLE.
REQ-012 MOVE: hold the jump outputs; when done_move==1, go to LAND.
REQ-013 LAND (one cycle) SHALL clear e_jump_qb, e_next_qb and e_bad_jump.
- Good jump: position_qb<=e_next_qb, update r and c, go to IDLE.
- Bad jump: decrement lives. If the result is 0, set game_over and go to OVER; otherwise set position to bit 0, r=c=0, pulse e_start_qb for one cycle, go to IDLE.
REQ-014 Button edges outside IDLE SHALL be discarded, not queued.
REQ-015 busy SHALL be 1 exactly in ISSUE, MOVE and LAND.
REQ-016 OVER: ignore buttons. On e_start==1, set lives=LIVES, clear game_over, go to INIT.
REQ-017 e_start in IDLE SHALL behave as OVER restart (full reinit). In ISSUE, MOVE or LAND it SHALL be ignored.

Reset
REQ-018 While reset==0:
- FSM state INIT.
- e_start_qb=0, e_jump_qb=0, e_next_qb=0, e_bad_jump=0.
- position_qb=1 (bit 0), r=c=0.
- lives=LIVES, game_over=0, busy=0, ack_timeout=0.
- Timeout counter and button edge registers cleared.
- visited_mask=1.
REQ-019 Reset asserted mid-jump SHALL abort immediately with no position or lives update.

Configuration
REQ-020 Macro QBERT_CUBE_VISIT_EN:
- Defined: on a good LAND, visited_mask |= new position. all_visited = (visited_mask == all ones). INIT clears the mask to bit 0.
- Undefined: visited_mask and all_visited are tied to 0 and no visit registers are inferred.

Structure
REQ-021 Package qbert_pkg SHALL hold:
- jump code localparams JUMP_NONE, JUMP_DR, JUMP_DL, JUMP_UR, JUMP_UL;
- the ctrl_state_t enum;
- the row/col-to-index function.
REQ-022 A sub-module qbert_cube_index SHALL be purely combinational: it takes (r,c,code) and returns the one-hot target and the bad flag.

Verification
REQ-023 Release reset: e_start_qb is high exactly 1 cycle; position_qb=28'h1; lives=3.
REQ-024 At (0,0), btn_dr edge: the next cycle shows e_jump_qb=001, e_next_qb=28'h4, e_bad_jump=0. Drive done_move 1→0→1: position_qb becomes 28'h4 one cycle after done_move returns high, and e_jump_qb=0.
REQ-025 At (0,0), btn_ul edge: e_bad_jump=1 and e_next_qb=0. After the done_move cycle, lives=2, position_qb=28'h1, and an e_start_qb pulse occurs.
REQ-026 Three bad jumps: game_over=1 and button edges are ignored. Pulse e_start: lives=3, game_over=0, followed by an e_start_qb pulse.
REQ-027 With ACK_TIMEOUT=16, hold done_move=1 after btn_dl: ack_timeout pulses on the 16th ISSUE cycle, e_jump_qb=0, position unchanged.
REQ-028 Simultaneous btn_dr and btn_ul edges: DR is issued. A btn_dl edge during MOVE is ignored. At row 6, btn_dl gives e_bad_jump=1.
